dmem_arbiter: RTL and testbench

Shares the single-port synchronous data memory (active-low CEN/WEN/OEN, 7-bit word address, 32-bit data) between two requesters: port 0, the SingleCycleMIPS load/store path, and port 1, a loader/debug DMA master. Issues at most one memory access per cycle and drives registered memory pins. Returns read data to the originating port after a fixed latency. Sits between the processor core and the data memory macro.

---
 rtl/dmem_arbiter_pkg.sv | 27 ++
 rtl/dmem_arbiter_if.sv | 22 ++
 rtl/dmem_rd_tag_pipe.sv | 39 +++
 rtl/dmem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and widths for the data-memory arbiter slice.
//   DMEM_AW / DMEM_DW : word address / data widths of the memory macro
//   port_id_t         : requester index (0 = CPU load/store, 1 = DMA/debug)
//   mem_cmd_t         : one memory command as presented by a requester
//   rd_tag_t          : read response tag carried down the latency pipe
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam int DMEM_AW = 7;
    localparam int DMEM_DW = 32;

    typedef logic port_id_t;

    typedef struct packed {
        logic               we;
        logic [DMEM_AW-1:0] addr;
        logic [DMEM_DW-1:0] wdata;
    } mem_cmd_t;

    typedef struct packed {
        logic     valid;
        port_id_t port;
    } rd_tag_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Request/response bundle for one requester of the data-memory arbiter.
//   req, we, addr, wdata : command, held stable by the requester until gnt
//   gnt                  : command accepted this cycle
//   rvalid               : read data for this requester is on the shared rdata
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface dmem_arbiter_if;
    import dmem_arb_pkg::*;

    logic               req;
    logic               we;
    logic [DMEM_AW-1:0] addr;
    logic [DMEM_DW-1:0] wdata;
    logic               gnt;
    logic               rvalid;

    modport master (output req, we, addr, wdata, input gnt, rvalid);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid);

endinterface

// File: rtl/dmem_rd_tag_pipe.sv
// -----------------------------------------------------------------------------
// dmem_rd_tag_pipe
// Fixed-length delay line of read tags; a tag pushed in cycle t appears on
// tag_out in cycle t+DEPTH. Synchronous flush on rst drops in-flight reads.
//   clk, rst : clock, synchronous active-high reset/flush
//   tag_in   : tag of the read granted this cycle (valid=0 when none)
//   tag_out  : tag whose read data is on the memory bus this cycle
// -----------------------------------------------------------------------------
module dmem_rd_tag_pipe
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH = 2   // >= 2 (1 pin cycle + at least 1 read latency)
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t [DEPTH-1:0] stage_q;
    rd_tag_t [DEPTH-1:0] stage_d;

    always_comb begin
        stage_d = {stage_q[DEPTH-2:0], tag_in};
    end

    // NOTE: every stage is cleared on reset, not just the data path; a stale
    // valid bit left in the line would fire a phantom rvalid after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port synchronous data memory between the CPU load/store
// path (p0) and a loader/debug DMA master (p1). One access per cycle, memory
// pins registered, read data returned to the originating port RD_LAT+1 cycles
// after its grant.
//   clk, rst        : clock, synchronous active-high reset
//   p0, p1          : requester bundles (slave modport)
//   rdata           : shared read data, zero unless an rvalid is high
//   CEN, WEN, OEN   : memory chip/write/output enables, active-low, registered
//   A, Data2Mem     : memory address / write data, registered
//   ReadDataMem     : memory read data
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration; otherwise
// port 0 has fixed priority.
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int RD_LAT = 1   // 1..4
) (
    input  logic               clk,
    input  logic               rst,
    dmem_arbiter_if.slave      p0,
    dmem_arbiter_if.slave      p1,
    output logic [DMEM_DW-1:0] rdata,
    output logic               CEN,
    output logic               WEN,
    output logic               OEN,
    output logic [DMEM_AW-1:0] A,
    output logic [DMEM_DW-1:0] Data2Mem,
    input  logic [DMEM_DW-1:0] ReadDataMem
);

    logic gnt0;
    logic gnt1;

    // Grants are suppressed in the reset cycle so nothing granted there can
    // reach the pins or the tag pipe.
`ifdef DMEM_ARB_RR_EN
    port_id_t ptr_q;
    port_id_t ptr_d;

    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (p0.req && (!p1.req || ptr_q == 1'b0)) begin
                gnt0 = 1'b1;
            end else if (p1.req) begin
                gnt1 = 1'b1;
            end
        end
    end

    // Pointer prefers the port that did not win last; idle cycles keep it.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt0) begin
            ptr_d = 1'b1;
        end else if (gnt1) begin
            ptr_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        gnt0 = !rst && p0.req;
        gnt1 = !rst && p1.req && !p0.req;
    end
`endif

    logic     gnt_any;
    mem_cmd_t cmd;

    always_comb begin
        gnt_any   = gnt0 | gnt1;
        cmd.we    = gnt1 ? p1.we    : p0.we;
        cmd.addr  = gnt1 ? p1.addr  : p0.addr;
        cmd.wdata = gnt1 ? p1.wdata : p0.wdata;
    end

    assign p0.gnt = gnt0;
    assign p1.gnt = gnt1;

    // Memory pin register.
    logic               cen_q, cen_d;
    logic               wen_q, wen_d;
    logic               oen_q, oen_d;
    logic [DMEM_AW-1:0] a_q,   a_d;
    logic [DMEM_DW-1:0] d2m_q, d2m_d;

    always_comb begin
        cen_d = 1'b1;
        wen_d = 1'b1;
        oen_d = 1'b1;
        a_d   = a_q;
        d2m_d = d2m_q;
        if (gnt_any) begin
            cen_d = 1'b0;
            wen_d = ~cmd.we;
            oen_d = cmd.we;
            a_d   = cmd.addr;
            if (cmd.we) begin
                d2m_d = cmd.wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cen_q <= 1'b1;
            wen_q <= 1'b1;
            oen_q <= 1'b1;
            a_q   <= '0;
            d2m_q <= '0;
        end else begin
            cen_q <= cen_d;
            wen_q <= wen_d;
            oen_q <= oen_d;
            a_q   <= a_d;
            d2m_q <= d2m_d;
        end
    end

    assign CEN      = cen_q;
    assign WEN      = wen_q;
    assign OEN      = oen_q;
    assign A        = a_q;
    assign Data2Mem = d2m_q;

    // Read response path: one stage for the pin register plus RD_LAT for the
    // memory itself.
    rd_tag_t tag_in;
    rd_tag_t tag_out;

    always_comb begin
        tag_in.valid = gnt_any && !cmd.we;
        tag_in.port  = gnt1;
    end

    dmem_rd_tag_pipe #(
        .DEPTH (1 + RD_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Responses are masked during reset so the flush is visible immediately.
    logic rvalid0;
    logic rvalid1;

    always_comb begin
        rvalid0 = tag_out.valid && !rst && (tag_out.port == 1'b0);
        rvalid1 = tag_out.valid && !rst && (tag_out.port == 1'b1);
        rdata   = (rvalid0 || rvalid1) ? ReadDataMem : '0;
    end

    assign p0.rvalid = rvalid0;
    assign p1.rvalid = rvalid1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Drives two arbiters (RD_LAT=1 and RD_LAT=3) with identical requester traffic
// and compares them every cycle with a transaction-level reference: grants
// from the arbitration rule, pin values from the last granted command, and
// read responses scheduled by grant cycle against a shadow copy of memory.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int NCYC = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    dmem_arbiter_if a_p0 ();
    dmem_arbiter_if a_p1 ();
    dmem_arbiter_if b_p0 ();
    dmem_arbiter_if b_p1 ();

    logic        cen_a, wen_a, oen_a, cen_b, wen_b, oen_b;
    logic [6:0]  a_a, a_b;
    logic [31:0] d2m_a, d2m_b, rdata_a, rdata_b, rdm_a, rdm_b;

    dmem_arbiter #(.RD_LAT(1)) u_dut_a (
        .clk(clk), .rst(rst), .p0(a_p0.slave), .p1(a_p1.slave), .rdata(rdata_a),
        .CEN(cen_a), .WEN(wen_a), .OEN(oen_a), .A(a_a), .Data2Mem(d2m_a),
        .ReadDataMem(rdm_a)
    );

    dmem_arbiter #(.RD_LAT(3)) u_dut_b (
        .clk(clk), .rst(rst), .p0(b_p0.slave), .p1(b_p1.slave), .rdata(rdata_b),
        .CEN(cen_b), .WEN(wen_b), .OEN(oen_b), .A(a_b), .Data2Mem(d2m_b),
        .ReadDataMem(rdm_b)
    );

    // Memory macros: write on the pin edge, read data RD_LAT cycles after it.
    logic [31:0] mem_a [128];
    logic [31:0] mem_b [128];
    logic [31:0] rp_a;
    logic [31:0] rp_b [3];

    always @(posedge clk) begin
        if (!cen_a && !wen_a) mem_a[a_a] <= d2m_a;
        rp_a <= (!cen_a && !oen_a) ? mem_a[a_a] : 32'h0;
    end
    assign rdm_a = rp_a;

    always @(posedge clk) begin
        if (!cen_b && !wen_b) mem_b[a_b] <= d2m_b;
        rp_b[0] <= (!cen_b && !oen_b) ? mem_b[a_b] : 32'h0;
        rp_b[1] <= rp_b[0];
        rp_b[2] <= rp_b[1];
    end
    assign rdm_b = rp_b[2];

    // Requester state: a pending command is held until the model grants it.
    logic        q_req [2];
    logic        q_we  [2];
    logic [6:0]  q_addr[2];
    logic [31:0] q_wd  [2];

    // Reference model state.
    bit          m_known;
    logic        m_cen, m_wen, m_oen;
    logic [6:0]  m_a;
    logic [31:0] m_d;
    bit          m_ptr;
    logic [31:0] shadow    [128];
    bit          shadow_ok [128];
    int          ev_a [NCYC];    // 0 none, 1 port0, 2 port1
    int          ev_b [NCYC];
    logic [31:0] ed   [NCYC*2];  // expected data, [cycle*2 + latency-set]
    bit          ek   [NCYC*2];
    int          cyc;
    logic        obs_g0, obs_g1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input logic we, input logic [6:0] addr,
                           input logic [31:0] wd);
        q_req[p]  = 1'b1;
        q_we[p]   = we;
        q_addr[p] = addr;
        q_wd[p]   = wd;
    endtask

    task automatic check_rsp(input string tag, input int ev, input int slot,
                             input logic rv0, input logic rv1, input logic [31:0] rd);
        check({tag, "_rvalid0"}, rv0, ev == 1);
        check({tag, "_rvalid1"}, rv1, ev == 2);
        if (ev == 0) check({tag, "_rdata_idle"}, rd, 32'h0);
        else if (ek[slot]) check({tag, "_rdata"}, rd, ed[slot]);
    endtask

    task automatic run_cycle(input logic rst_i);
        logic       e_g0, e_g1;
        int         gp, e_a, e_b;
        rst       = rst_i;
        a_p0.req  = q_req[0]; a_p0.we = q_we[0]; a_p0.addr = q_addr[0]; a_p0.wdata = q_wd[0];
        a_p1.req  = q_req[1]; a_p1.we = q_we[1]; a_p1.addr = q_addr[1]; a_p1.wdata = q_wd[1];
        b_p0.req  = q_req[0]; b_p0.we = q_we[0]; b_p0.addr = q_addr[0]; b_p0.wdata = q_wd[0];
        b_p1.req  = q_req[1]; b_p1.we = q_we[1]; b_p1.addr = q_addr[1]; b_p1.wdata = q_wd[1];
        @(negedge clk);

        e_g0 = 1'b0;
        e_g1 = 1'b0;
        if (!rst_i) begin
            if (q_req[0] && q_req[1]) begin
`ifdef DMEM_ARB_RR_EN
                if (m_ptr) e_g1 = 1'b1; else e_g0 = 1'b1;
`else
                e_g0 = 1'b1;
`endif
            end else begin
                e_g0 = q_req[0];
                e_g1 = q_req[1];
            end
        end

        obs_g0 = a_p0.gnt;
        obs_g1 = a_p1.gnt;
        check("gnt0_a", a_p0.gnt, e_g0);
        check("gnt1_a", a_p1.gnt, e_g1);
        check("gnt0_b", b_p0.gnt, e_g0);
        check("gnt1_b", b_p1.gnt, e_g1);

        if (m_known) begin
            check("cen_a", cen_a, m_cen); check("wen_a", wen_a, m_wen);
            check("oen_a", oen_a, m_oen); check("addr_a", a_a, m_a);
            check("d2m_a", d2m_a, m_d);
            check("cen_b", cen_b, m_cen); check("wen_b", wen_b, m_wen);
            check("oen_b", oen_b, m_oen); check("addr_b", a_b, m_a);
            check("d2m_b", d2m_b, m_d);
        end

        e_a = rst_i ? 0 : ev_a[cyc];
        e_b = rst_i ? 0 : ev_b[cyc];
        check_rsp("a", e_a, cyc*2,     a_p0.rvalid, a_p1.rvalid, rdata_a);
        check_rsp("b", e_b, cyc*2 + 1, b_p0.rvalid, b_p1.rvalid, rdata_b);

        // Effects of the coming clock edge.
        if (rst_i) begin
            m_known = 1'b1;
            m_cen = 1'b1; m_wen = 1'b1; m_oen = 1'b1; m_a = '0; m_d = '0;
            m_ptr = 1'b0;
            for (int k = cyc + 1; k <= cyc + 4; k++) begin
                ev_a[k] = 0;
                ev_b[k] = 0;
            end
        end else if (e_g0 || e_g1) begin
            gp    = e_g1 ? 1 : 0;
            m_cen = 1'b0;
            m_wen = ~q_we[gp];
            m_oen = q_we[gp];
            m_a   = q_addr[gp];
            if (q_we[gp]) begin
                m_d = q_wd[gp];
                shadow[q_addr[gp]]    = q_wd[gp];
                shadow_ok[q_addr[gp]] = 1'b1;
            end else begin
                ev_a[cyc + 2]        = gp + 1;
                ed[(cyc + 2) * 2]    = shadow[q_addr[gp]];
                ek[(cyc + 2) * 2]    = shadow_ok[q_addr[gp]];
                ev_b[cyc + 4]        = gp + 1;
                ed[(cyc + 4) * 2 + 1] = shadow[q_addr[gp]];
                ek[(cyc + 4) * 2 + 1] = shadow_ok[q_addr[gp]];
            end
            q_req[gp] = 1'b0;
            m_ptr     = (gp == 0);
        end else begin
            m_cen = 1'b1; m_wen = 1'b1; m_oen = 1'b1;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        cyc     = 0;
        m_known = 1'b0;
        m_ptr   = 1'b0;
        m_cen = 1'b1; m_wen = 1'b1; m_oen = 1'b1; m_a = '0; m_d = '0;
        for (int i = 0; i < 128; i++) begin
            shadow[i]    = '0;
            shadow_ok[i] = 1'b0;
        end
        for (int i = 0; i < NCYC; i++) begin
            ev_a[i] = 0;
            ev_b[i] = 0;
        end
        for (int i = 0; i < NCYC*2; i++) begin
            ed[i] = '0;
            ek[i] = 1'b0;
        end
        for (int p = 0; p < 2; p++) begin
            q_req[p] = 1'b0; q_we[p] = 1'b0; q_addr[p] = '0; q_wd[p] = '0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset held for two cycles with both ports requesting.
        set_req(0, 1'b0, 7'h11, 32'h0);
        set_req(1, 1'b0, 7'h22, 32'h0);
        run_cycle(1'b1);
        run_cycle(1'b1);
        q_req[0] = 1'b0;
        q_req[1] = 1'b0;
        run_cycle(1'b0);

        // Single write then read-back on port 0, then a port 1 read.
        set_req(0, 1'b1, 7'h12, 32'hDEAD_BEEF);
        run_cycle(1'b0);
        set_req(0, 1'b0, 7'h12, 32'h0);
        run_cycle(1'b0);
        run_cycle(1'b0);
        set_req(1, 1'b0, 7'h12, 32'h0);
        run_cycle(1'b0);
        run_cycle(1'b0);
        run_cycle(1'b0);

        // Contention: both ports read every cycle for four cycles.
        set_req(0, 1'b1, 7'h30, 32'h1234_5678);
        run_cycle(1'b0);
        set_req(1, 1'b1, 7'h31, 32'h9ABC_DEF0);
        run_cycle(1'b0);
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1'b0, 7'h30, 32'h0);
            set_req(1, 1'b0, 7'h31, 32'h0);
            run_cycle(1'b0);
`ifdef DMEM_ARB_RR_EN
            check("contention_gnt1", obs_g1, 32'(i & 1));
`else
            check("contention_gnt1", obs_g1, 32'h0);
`endif
        end
        q_req[0] = 1'b0;
        q_req[1] = 1'b0;
        for (int i = 0; i < 5; i++) run_cycle(1'b0);

        // Idle hold after a write to 0x05.
        set_req(1, 1'b1, 7'h05, 32'hCAFE_F00D);
        run_cycle(1'b0);
        for (int i = 0; i < 4; i++) run_cycle(1'b0);
        set_req(0, 1'b0, 7'h05, 32'h0);
        set_req(1, 1'b0, 7'h05, 32'h0);
        run_cycle(1'b0);
        run_cycle(1'b0);
        for (int i = 0; i < 5; i++) run_cycle(1'b0);

        // Reset one cycle after a read is granted: no response may appear.
        set_req(0, 1'b0, 7'h12, 32'h0);
        run_cycle(1'b0);
        run_cycle(1'b1);
        for (int i = 0; i < 5; i++) run_cycle(1'b0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 700; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!q_req[p] && $urandom_range(0, 99) < 60) begin
                    set_req(p, 1'($urandom_range(0, 1)),
                            ($urandom_range(0, 9) == 0) ? 7'h7F : 7'($urandom_range(0, 15)),
                            $urandom);
                end
            end
            run_cycle(1'($urandom_range(0, 59) == 0));
        end
        q_req[0] = 1'b0;
        q_req[1] = 1'b0;
        for (int i = 0; i < 6; i++) run_cycle(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
